// File: rtl/decsym_rle_expander.sv
// ---------------------------------------------------------------------------
// decsym_rle_expander
//
// Turns decoded JPEG (run/size, raw amplitude) symbol tokens into a flat
// stream of exactly BLOCK_LEN coefficients per block, in zig-zag order.
// The DC coefficient is rebuilt from a per-component predictor. AC zero
// runs, ZRL (16 zeros) and EOB (zero fill to the end of the block) are
// expanded here. Components are visited round-robin, one block each per MCU.
//
// Ports:
//   clock   - clock
//   reset   - asynchronous, active-low reset
//   dc_clr  - predictor clear request (only when DECSYM_DCPRED_CLR_EN is set)
//   sym_d   - token {rs[7:0], raw[AMP_W-1:0]}; rs[7:4]=run, rs[3:0]=size
//   sym_v   - token valid
//   sym_e   - end-of-stream marker, qualified by sym_v
//   sym_b   - token backpressure (1 = token not consumed this cycle)
//   coef_d  - coefficient value (two's complement, COEF_W bits)
//   coef_v  - coefficient valid
//   coef_e  - end-of-stream marker on the coefficient side
//   coef_b  - backpressure from the coefficient consumer
//   comp    - component index of the block in flight
//   state   - current FSM state code
//   err     - sticky protocol error flag
//
// Optional feature (macro DECSYM_DCPRED_CLR_EN):
//   Adds the dc_clr input. While waiting for a DC token with no token taken
//   in that cycle, dc_clr zeroes every predictor and restarts at component
//   0, which is what a JPEG restart marker needs. Without the macro the
//   predictors are cleared only by reset.
// ---------------------------------------------------------------------------
module decsym_rle_expander #(
  parameter int COEF_W    = 12,
  parameter int AMP_W     = 11,
  parameter int BLOCK_LEN = 64,
  parameter int NUM_COMP  = 3,
  localparam int COMP_W   = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef DECSYM_DCPRED_CLR_EN
  input  logic                 dc_clr,
`endif
  input  logic [8+AMP_W-1:0]   sym_d,
  input  logic                 sym_v,
  input  logic                 sym_e,
  output logic                 sym_b,
  output logic [COEF_W-1:0]    coef_d,
  output logic                 coef_v,
  output logic                 coef_e,
  input  logic                 coef_b,
  output logic [COMP_W-1:0]    comp,
  output logic [2:0]           state,
  output logic                 err
);

  // State codes. The numeric values are visible on the state port, so they
  // must not be renumbered.
  localparam logic [2:0] DC   = 3'd0;
  localparam logic [2:0] AC   = 3'd1;
  localparam logic [2:0] ZERO = 3'd2;
  localparam logic [2:0] EMIT = 3'd3;
  localparam logic [2:0] FILL = 3'd4;
  localparam logic [2:0] EOS  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam int K_W = $clog2(BLOCK_LEN);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(BLOCK_LEN - 1);
  localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(NUM_COMP - 1);
  localparam int PRED_N = 2 ** COMP_W;

  // Registered datapath state
  logic [K_W-1:0]    kIdx;
  logic [4:0]        zeroCnt;
  logic              pendCoef;
  logic [COEF_W-1:0] coefVal;
  // Sized to a power of two so comp can index it directly for any
  // NUM_COMP; entries at or above NUM_COMP are never selected.
  logic [COEF_W-1:0] predReg [PRED_N];

  // Token field split
  logic [7:0]        tokRs;
  logic [3:0]        tokRun;
  logic [3:0]        tokSize;
  logic [AMP_W-1:0]  tokRaw;
  logic [COEF_W-1:0] extVal;
  logic              extErr;
  logic [COEF_W-1:0] dcVal;
  logic [COMP_W-1:0] compNext;
  logic              xfer;

  // JPEG EXTEND: a size-s amplitude whose top bit is clear is negative and
  // encodes v - (2^s - 1). Sizes above AMP_W are illegal and give 0; the
  // caller raises err separately.
  function automatic logic [COEF_W-1:0] extend(input logic [AMP_W-1:0] raw,
                                               input logic [3:0] size);
    logic [31:0] mask;
    logic [31:0] v;
    logic [31:0] r;
    mask = (32'd1 << size) - 32'd1;
    v    = 32'(raw) & mask;
    r    = 32'd0;
    if (size != 4'd0 && int'(size) <= AMP_W) begin
      if (v[{1'b0, size} - 5'd1]) begin
        r = v;
      end else begin
        r = v - mask;
      end
    end
    return r[COEF_W-1:0];
  endfunction

  // Field decode of the incoming token and the DC reconstruction, which
  // wraps modulo 2^COEF_W like the predictor register itself.
  always_comb begin
    tokRs    = sym_d[8+AMP_W-1:AMP_W];
    tokRun   = tokRs[7:4];
    tokSize  = tokRs[3:0];
    tokRaw   = sym_d[AMP_W-1:0];
    extVal   = extend(tokRaw, tokSize);
    extErr   = int'(tokSize) > AMP_W;
    dcVal    = predReg[comp] + extVal;
    compNext = (comp == LAST_COMP) ? '0 : comp + COMP_W'(1);
  end

  // Output decode straight from the registered state. sym_b also depends
  // on sym_v/sym_e because an end-of-stream token met in the middle of a
  // block is refused rather than consumed, and it is held high throughout
  // reset.
  always_comb begin
    coef_v = (state == ZERO) || (state == EMIT) ||
             (state == FILL) || (state == EOS);
    coef_e = (state == EOS);
    coef_d = (state == EMIT) ? coefVal : '0;
    sym_b  = !reset ||
             !((state == DC) || (state == AC && !(sym_v && sym_e)));
    xfer   = coef_v && !coef_b;
  end

  // Main sequencer. Every path that finishes a block rewinds the
  // coefficient index, advances to the next component and returns to DC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= DC;
      kIdx     <= '0;
      comp     <= '0;
      zeroCnt  <= '0;
      pendCoef <= 1'b0;
      coefVal  <= '0;
      err      <= 1'b0;
      for (int i = 0; i < PRED_N; i++) begin
        predReg[i] <= '0;
      end
    end else begin
      case (state)
        DC: begin
          if (sym_v) begin
            if (sym_e) begin
              state <= EOS;
            end else begin
              predReg[comp] <= dcVal;
              coefVal       <= dcVal;
              if (extErr) begin
                err <= 1'b1;
              end
              state <= EMIT;
            end
          end
`ifdef DECSYM_DCPRED_CLR_EN
          else if (dc_clr) begin
            for (int i = 0; i < PRED_N; i++) begin
              predReg[i] <= '0;
            end
            comp <= '0;
          end
`endif
        end

        AC: begin
          if (sym_v) begin
            if (sym_e) begin
              // Stream ended inside a block: refuse the token, pad the
              // block out with zeros and let DC take the marker.
              err   <= 1'b1;
              state <= FILL;
            end else if (tokRs == 8'h00) begin
              state <= FILL;
            end else if (tokRs == 8'hF0) begin
              zeroCnt  <= 5'd16;
              pendCoef <= 1'b0;
              state    <= ZERO;
            end else if (tokRun != 4'd0) begin
              zeroCnt  <= {1'b0, tokRun};
              coefVal  <= extVal;
              pendCoef <= 1'b1;
              if (extErr) begin
                err <= 1'b1;
              end
              state <= ZERO;
            end else begin
              coefVal <= extVal;
              if (extErr) begin
                err <= 1'b1;
              end
              state <= EMIT;
            end
          end
        end

        ZERO: begin
          if (xfer) begin
            if (kIdx == LAST_K) begin
              // Block is full. Anything still owed (zeros or the pending
              // coefficient) no longer fits and is dropped.
              if (zeroCnt != 5'd1 || pendCoef) begin
                err <= 1'b1;
              end
              zeroCnt  <= '0;
              pendCoef <= 1'b0;
              kIdx     <= '0;
              comp     <= compNext;
              state    <= DC;
            end else begin
              kIdx    <= kIdx + K_W'(1);
              zeroCnt <= zeroCnt - 5'd1;
              if (zeroCnt == 5'd1) begin
                pendCoef <= 1'b0;
                state    <= pendCoef ? EMIT : AC;
              end
            end
          end
        end

        EMIT: begin
          if (xfer) begin
            if (kIdx == LAST_K) begin
              kIdx  <= '0;
              comp  <= compNext;
              state <= DC;
            end else begin
              kIdx  <= kIdx + K_W'(1);
              state <= AC;
            end
          end
        end

        FILL: begin
          if (xfer) begin
            if (kIdx == LAST_K) begin
              kIdx  <= '0;
              comp  <= compNext;
              state <= DC;
            end else begin
              kIdx <= kIdx + K_W'(1);
            end
          end
        end

        EOS: begin
          if (xfer) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decsym_rle_expander.sv
// ---------------------------------------------------------------------------
// tb_decsym_rle_expander
//
// Directed bench for decsym_rle_expander with a single component and
// 64-coefficient blocks. Tokens are driven one at a time; coefficients the
// consumer accepts are captured into a queue and compared against
// hand-computed blocks.
// ---------------------------------------------------------------------------
module tb_decsym_rle_expander;

  localparam int COEF_W    = 12;
  localparam int AMP_W     = 11;
  localparam int BLOCK_LEN = 64;
  localparam int NUM_COMP  = 1;

  logic                clock = 1'b0;
  logic                reset;
  logic [8+AMP_W-1:0]  sym_d;
  logic                sym_v;
  logic                sym_e;
  logic                sym_b;
  logic [COEF_W-1:0]   coef_d;
  logic                coef_v;
  logic                coef_e;
  logic                coef_b;
  logic [0:0]          comp;
  logic [2:0]          state;
  logic                err;
`ifdef DECSYM_DCPRED_CLR_EN
  logic                dc_clr;
`endif

  int errors = 0;
  int checks = 0;

  logic [COEF_W-1:0] coefQ[$];
  logic              eQ[$];
  logic [COEF_W-1:0] expBlk [BLOCK_LEN];

  decsym_rle_expander #(
    .COEF_W(COEF_W),
    .AMP_W(AMP_W),
    .BLOCK_LEN(BLOCK_LEN),
    .NUM_COMP(NUM_COMP)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef DECSYM_DCPRED_CLR_EN
    .dc_clr(dc_clr),
`endif
    .sym_d(sym_d),
    .sym_v(sym_v),
    .sym_e(sym_e),
    .sym_b(sym_b),
    .coef_d(coef_d),
    .coef_v(coef_v),
    .coef_e(coef_e),
    .coef_b(coef_b),
    .comp(comp),
    .state(state),
    .err(err)
  );

  always #5 clock = ~clock;

  // Capture every accepted coefficient half a cycle before the edge that
  // completes the transfer.
  always @(negedge clock) begin
    if (reset && coef_v && !coef_b) begin
      coefQ.push_back(coef_d);
      eQ.push_back(coef_e);
    end
  end

  // Present one token and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] rs, input logic [AMP_W-1:0] raw,
                               input logic e);
    bit taken;
    taken = 1'b0;
    @(posedge clock);
    #1;
    sym_d = {rs, raw};
    sym_v = 1'b1;
    sym_e = e;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clock);
      if (!sym_b) taken = 1'b1;
    end
    if (!taken) begin
      errors++;
      checks++;
      $display("[TB] FAIL token_accept: rs=%h not consumed within 200 cycles", rs);
    end
    @(posedge clock);
    #1;
    sym_v = 1'b0;
    sym_e = 1'b0;
    sym_d = '0;
  endtask

  // Wait until n coefficients have been captured, bounded.
  task automatic waitCoefs(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clock);
      #1;
      if (coefQ.size() >= n) done = 1'b1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("[TB] FAIL coef_count: got %0d coefficients, wanted %0d", coefQ.size(), n);
    end
    repeat (2) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clearExpected();
    for (int i = 0; i < BLOCK_LEN; i++) expBlk[i] = '0;
    coefQ.delete();
    eQ.delete();
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    coefQ.delete();
    eQ.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    sym_v  = 1'b0;
    sym_e  = 1'b0;
    sym_d  = '0;
    coef_b = 1'b0;
`ifdef DECSYM_DCPRED_CLR_EN
    dc_clr = 1'b0;
`endif
    #12;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d want 0", state); end
    checks++; if (sym_b !== 1'b1) begin errors++; $display("[TB] FAIL rst_sym_b: got %b want 1", sym_b); end
    checks++; if (coef_v !== 1'b0) begin errors++; $display("[TB] FAIL rst_coef_v: got %b want 0", coef_v); end
    checks++; if (coef_e !== 1'b0) begin errors++; $display("[TB] FAIL rst_coef_e: got %b want 0", coef_e); end
    checks++; if (coef_d !== 12'h000) begin errors++; $display("[TB] FAIL rst_coef_d: got %h want 000", coef_d); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    checks++; if (comp !== 1'b0) begin errors++; $display("[TB] FAIL rst_comp: got %0d want 0", comp); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (sym_b !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_sym_b: got %b want 0", sym_b); end
  endtask

  // DC size 3 raw 101 = +5, then EOB: 5 followed by 63 zeros.
  task automatic test_dc_eob();
    logic [COEF_W-1:0] got;
    clearExpected();
    expBlk[0] = 12'd5;
    applyStimulus(8'h03, 11'b101, 1'b0);
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() != BLOCK_LEN) begin errors++; $display("[TB] FAIL dc_eob_len: got %0d want %0d", coefQ.size(), BLOCK_LEN); end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      got = (i < coefQ.size()) ? coefQ[i] : 'x;
      checks++; if (got !== expBlk[i]) begin errors++; $display("[TB] FAIL dc_eob_coef[%0d]: got %h want %h", i, got, expBlk[i]); end
    end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL dc_eob_state: got %0d want 0", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL dc_eob_err: got %b want 0", err); end
  endtask

  // DC size 2 raw 00 = -3 (pred 5 -> 2); rs=0x21 raw 1: two zeros then +1.
  task automatic test_run();
    logic [COEF_W-1:0] got;
    clearExpected();
    expBlk[0] = 12'd2;
    expBlk[3] = 12'd1;
    applyStimulus(8'h02, 11'b00, 1'b0);
    applyStimulus(8'h21, 11'b1, 1'b0);
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() != BLOCK_LEN) begin errors++; $display("[TB] FAIL run_len: got %0d want %0d", coefQ.size(), BLOCK_LEN); end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      got = (i < coefQ.size()) ? coefQ[i] : 'x;
      checks++; if (got !== expBlk[i]) begin errors++; $display("[TB] FAIL run_coef[%0d]: got %h want %h", i, got, expBlk[i]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL run_err: got %b want 0", err); end
  endtask

  // DC +1 (pred 2 -> 3); rs=0x51 raw 0: five zeros then -1. The consumer
  // stalls for 5 cycles on entry to the zero run.
  task automatic test_backpressure();
    logic [COEF_W-1:0] got;
    clearExpected();
    expBlk[0] = 12'd3;
    expBlk[6] = 12'hFFF;
    applyStimulus(8'h01, 11'b1, 1'b0);
    applyStimulus(8'h51, 11'b0, 1'b0);
    coef_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (coef_v !== 1'b1) begin errors++; $display("[TB] FAIL bp_coef_v[%0d]: got %b want 1", i, coef_v); end
      checks++; if (coef_d !== 12'h000) begin errors++; $display("[TB] FAIL bp_coef_d[%0d]: got %h want 000", i, coef_d); end
      checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL bp_state[%0d]: got %0d want 2", i, state); end
      checks++; if (sym_b !== 1'b1) begin errors++; $display("[TB] FAIL bp_sym_b[%0d]: got %b want 1", i, sym_b); end
    end
    checks++; if (coefQ.size() != 1) begin errors++; $display("[TB] FAIL bp_stalled_count: got %0d want 1", coefQ.size()); end
    @(posedge clock);
    #1;
    coef_b = 1'b0;
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() != BLOCK_LEN) begin errors++; $display("[TB] FAIL bp_len: got %0d want %0d", coefQ.size(), BLOCK_LEN); end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      got = (i < coefQ.size()) ? coefQ[i] : 'x;
      checks++; if (got !== expBlk[i]) begin errors++; $display("[TB] FAIL bp_coef[%0d]: got %h want %h", i, got, expBlk[i]); end
    end
  endtask

  // DC size 0 (stays 3); rs=0x81 raw 1 brings k to 10; an end-of-stream
  // token there is refused and the block is padded with 54 zeros. The
  // marker is then taken in DC and comes out as the EOS coefficient.
  task automatic test_eos_fill();
    logic [COEF_W-1:0] got;
    bit inAc;
    clearExpected();
    expBlk[0] = 12'd3;
    expBlk[9] = 12'd1;
    applyStimulus(8'h00, 11'd0, 1'b0);
    applyStimulus(8'h81, 11'b1, 1'b0);
    inAc = 1'b0;
    for (int i = 0; i < 100 && !inAc; i++) begin
      @(posedge clock);
      #1;
      if (state == 3'd1) inAc = 1'b1;
    end
    checks++; if (!inAc) begin errors++; $display("[TB] FAIL eos_reach_ac: state %0d, wanted 1", state); end
    checks++; if (coefQ.size() != 10) begin errors++; $display("[TB] FAIL eos_k: got %0d want 10", coefQ.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL eos_err_before: got %b want 0", err); end
    sym_d = '0;
    sym_v = 1'b1;
    sym_e = 1'b1;
    @(negedge clock);
    checks++; if (sym_b !== 1'b1) begin errors++; $display("[TB] FAIL eos_ac_sym_b: got %b want 1", sym_b); end
    @(posedge clock);
    #1;
    sym_v = 1'b0;
    sym_e = 1'b0;
    checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL eos_fill_state: got %0d want 4", state); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL eos_err_after: got %b want 1", err); end
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() != BLOCK_LEN) begin errors++; $display("[TB] FAIL eos_len: got %0d want %0d", coefQ.size(), BLOCK_LEN); end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      got = (i < coefQ.size()) ? coefQ[i] : 'x;
      checks++; if (got !== expBlk[i]) begin errors++; $display("[TB] FAIL eos_coef[%0d]: got %h want %h", i, got, expBlk[i]); end
    end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL eos_back_dc: got %0d want 0", state); end
    coefQ.delete();
    eQ.delete();
    applyStimulus(8'h00, 11'd0, 1'b1);
    checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL eos_state: got %0d want 5", state); end
    checks++; if (coef_v !== 1'b1) begin errors++; $display("[TB] FAIL eos_coef_v: got %b want 1", coef_v); end
    checks++; if (coef_e !== 1'b1) begin errors++; $display("[TB] FAIL eos_coef_e: got %b want 1", coef_e); end
    checks++; if (coef_d !== 12'h000) begin errors++; $display("[TB] FAIL eos_coef_d: got %h want 000", coef_d); end
    @(posedge clock);
    #1;
    checks++; if (state !== 3'd6) begin errors++; $display("[TB] FAIL done_state: got %0d want 6", state); end
    checks++; if (sym_b !== 1'b1) begin errors++; $display("[TB] FAIL done_sym_b: got %b want 1", sym_b); end
    checks++; if (coef_v !== 1'b0) begin errors++; $display("[TB] FAIL done_coef_v: got %b want 0", coef_v); end
    checks++; if (eQ.size() != 1 || eQ[0] !== 1'b1) begin errors++; $display("[TB] FAIL eos_xfer: got %0d transfers want 1 with end set", eQ.size()); end
  endtask

  // After reset: DC size 4 raw 1001 = +9; ZRL x3 fills k=1..48; rs=0xF1
  // fills k=49..63 with zeros and the pending -1 no longer fits.
  task automatic test_zrl_overflow();
    logic [COEF_W-1:0] got;
    pulseReset();
    clearExpected();
    expBlk[0] = 12'd9;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL zrl_err_reset: got %b want 0", err); end
    applyStimulus(8'h04, 11'b1001, 1'b0);
    applyStimulus(8'hF0, 11'd0, 1'b0);
    applyStimulus(8'hF0, 11'd0, 1'b0);
    applyStimulus(8'hF0, 11'd0, 1'b0);
    applyStimulus(8'hF1, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() != BLOCK_LEN) begin errors++; $display("[TB] FAIL zrl_len: got %0d want %0d", coefQ.size(), BLOCK_LEN); end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      got = (i < coefQ.size()) ? coefQ[i] : 'x;
      checks++; if (got !== expBlk[i]) begin errors++; $display("[TB] FAIL zrl_coef[%0d]: got %h want %h", i, got, expBlk[i]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL zrl_err: got %b want 1", err); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL zrl_state: got %0d want 0", state); end
  endtask

`ifdef DECSYM_DCPRED_CLR_EN
  // +7, +7 accumulates to 14; after a dc_clr pulse +7 comes out as 7 again.
  task automatic test_dcclr();
    pulseReset();
    clearExpected();
    applyStimulus(8'h03, 11'b111, 1'b0);
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() == 0 || coefQ[0] !== 12'd7) begin errors++; $display("[TB] FAIL clr_first: got %h want 007", (coefQ.size() > 0) ? coefQ[0] : 12'hxxx); end
    clearExpected();
    applyStimulus(8'h03, 11'b111, 1'b0);
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() == 0 || coefQ[0] !== 12'd14) begin errors++; $display("[TB] FAIL clr_accum: got %h want 00e", (coefQ.size() > 0) ? coefQ[0] : 12'hxxx); end
    @(posedge clock);
    #1;
    dc_clr = 1'b1;
    @(posedge clock);
    #1;
    dc_clr = 1'b0;
    clearExpected();
    applyStimulus(8'h03, 11'b111, 1'b0);
    applyStimulus(8'h00, 11'd0, 1'b0);
    waitCoefs(BLOCK_LEN);
    checks++; if (coefQ.size() == 0 || coefQ[0] !== 12'd7) begin errors++; $display("[TB] FAIL clr_after: got %h want 007", (coefQ.size() > 0) ? coefQ[0] : 12'hxxx); end
    checks++; if (comp !== 1'b0) begin errors++; $display("[TB] FAIL clr_comp: got %0d want 0", comp); end
  endtask
`endif

  initial begin
    $display("[TB] decsym_rle_expander directed bench start");
    test_reset();
    test_dc_eob();
    test_run();
    test_backpressure();
    test_eos_fill();
    test_zrl_overflow();
`ifdef DECSYM_DCPRED_CLR_EN
    test_dcclr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
